// File: rtl/gcd_stream.sv
// Streaming binary (Stein) GCD with valid/ready on both sides.
// Optional out_coprime flag is enabled with `define GCD_COPRIME_EN.
module gcd_stream #(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd
`ifdef GCD_COPRIME_EN
    ,
    output logic             out_coprime
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_a_n;
    logic [WIDTH-1:0] w_b_n;
    logic [KW-1:0]    r_k;
    logic [KW-1:0]    w_k_n;
    logic [WIDTH-1:0] r_gcd;
    logic [WIDTH-1:0] w_gcd_n;
    logic [WIDTH-1:0] w_a_m_b;
    logic [WIDTH-1:0] w_b_m_a;
    logic [WIDTH-1:0] w_a_or_b;
    logic [WIDTH-1:0] w_shl;

    assign w_a_m_b  = r_a - r_b;
    assign w_b_m_a  = r_b - r_a;
    assign w_a_or_b = r_a | r_b;
    assign w_shl    = r_a << r_k;

    // Gated by nrst so in_ready is low for the whole reset window.
    assign in_ready  = nrst && (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_gcd   = r_gcd;

    always_comb begin
        w_state_n = r_state;
        w_a_n     = r_a;
        w_b_n     = r_b;
        w_k_n     = r_k;
        w_gcd_n   = r_gcd;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_a_n     = in_a;
                    w_b_n     = in_b;
                    w_k_n     = '0;
                    w_state_n = S_RUN;
                end
            end
            S_RUN: begin
                // Zero operands resolve on the first RUN cycle.
                if (r_a == '0 || r_b == '0) begin
                    w_gcd_n   = w_a_or_b;
                    w_state_n = S_DONE;
                end else if (r_a == r_b) begin
                    w_gcd_n   = w_shl;
                    w_state_n = S_DONE;
                end else if (!r_a[0] && !r_b[0]) begin
                    w_a_n = r_a >> 1;
                    w_b_n = r_b >> 1;
                    w_k_n = r_k + KW'(1);
                end else if (!r_a[0]) begin
                    w_a_n = r_a >> 1;
                end else if (!r_b[0]) begin
                    w_b_n = r_b >> 1;
                end else if (r_a > r_b) begin
                    w_a_n = w_a_m_b >> 1;
                end else begin
                    w_b_n = w_b_m_a >> 1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_gcd   <= '0;
        end else begin
            r_state <= w_state_n;
            r_a     <= w_a_n;
            r_b     <= w_b_n;
            r_k     <= w_k_n;
            r_gcd   <= w_gcd_n;
        end
    end

`ifdef GCD_COPRIME_EN
    logic r_coprime;
    logic w_coprime_n;

    always_comb begin
        w_coprime_n = r_coprime;
        if (r_state == S_RUN && w_state_n == S_DONE) begin
            w_coprime_n = (w_gcd_n == WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_coprime <= 1'b0;
        end else begin
            r_coprime <= w_coprime_n;
        end
    end

    assign out_coprime = r_coprime;
`endif

endmodule

// File: tb/tb_gcd_stream.sv
// Directed + random bench for gcd_stream (WIDTH=8 and WIDTH=16 instances).
module tb_gcd_stream;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  in_a8 = '0;
    logic [7:0]  in_b8 = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [7:0]  out_gcd8;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] in_a16 = '0;
    logic [15:0] in_b16 = '0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [15:0] out_gcd16;

`ifdef GCD_COPRIME_EN
    logic        out_coprime8;
    logic        out_coprime16;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_stream #(.WIDTH(8)) u8 (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid8),
        .in_ready   (in_ready8),
        .in_a       (in_a8),
        .in_b       (in_b8),
        .out_valid  (out_valid8),
        .out_ready  (out_ready8),
        .out_gcd    (out_gcd8)
`ifdef GCD_COPRIME_EN
        ,
        .out_coprime(out_coprime8)
`endif
    );

    gcd_stream #(.WIDTH(16)) u16 (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid16),
        .in_ready   (in_ready16),
        .in_a       (in_a16),
        .in_b       (in_b16),
        .out_valid  (out_valid16),
        .out_ready  (out_ready16),
        .out_gcd    (out_gcd16)
`ifdef GCD_COPRIME_EN
        ,
        .out_coprime(out_coprime16)
`endif
    );

    // Euclid's algorithm: a different route to the same answer.
    function automatic int unsigned ref_gcd(int unsigned a, int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] g, output int lat);
        int n;
        n = 0;
        while (!in_ready8 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        in_valid8 = 1'b1;
        in_a8 = a;
        in_b8 = b;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        g = out_gcd8;
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] g, output int lat);
        int n;
        n = 0;
        while (!in_ready16 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        in_valid16 = 1'b1;
        in_a16 = a;
        in_b16 = b;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        g = out_gcd16;
    endtask

    task automatic take8();
        out_ready8 = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run8(input string tag, input logic [7:0] a,
                        input logic [7:0] b);
        logic [7:0] g;
        int lat;
        int unsigned e;
        e = ref_gcd(a, b);
        op8(a, b, g, lat);
        check({tag, "_valid"}, out_valid8, 1);
        check({tag, "_gcd"}, g, e);
        check({tag, "_latbound"}, lat <= 18, 1);
`ifdef GCD_COPRIME_EN
        check({tag, "_cop"}, out_coprime8, e == 1);
`endif
        take8();
        check({tag, "_back_idle"}, in_ready8, 1);
    endtask

    initial begin
        logic [7:0]  g8;
        logic [15:0] g16;
        logic [15:0] ra;
        logic [15:0] rb;
        int          lat;
        int          n;
        bit          stable;
        bit          seen;

        // Reset state while nrst is held low
        #2;
        check("rst_in_ready", in_ready8, 0);
        check("rst_out_valid", out_valid8, 0);
        check("rst_out_gcd", out_gcd8, 0);
        check("rst16_in_ready", in_ready16, 0);
`ifdef GCD_COPRIME_EN
        check("rst_cop", out_coprime8, 0);
`endif
        @(posedge clk); #1;
        @(posedge clk); #3;
        nrst = 1'b1;
        #1;
        check("post_rst_ready", in_ready8, 1);
        @(posedge clk); #1;

        // 21/35: exact latency of three edges
        op8(8'd21, 8'd35, g8, lat);
        check("g21_35", g8, 7);
        check("lat21_35", lat, 3);
`ifdef GCD_COPRIME_EN
        check("cop21_35", out_coprime8, 0);
`endif
        take8();

        run8("g48_18", 8'd48, 8'd18);
        run8("g17_5", 8'd17, 8'd5);

        // Zero operand resolves one edge after accept
        op8(8'd0, 8'd9, g8, lat);
        check("g0_9", g8, 9);
        check("lat0_9", lat, 1);
        take8();
        run8("g0_0", 8'd0, 8'd0);
        run8("g0_1", 8'd0, 8'd1);
        run8("g255_255", 8'd255, 8'd255);
        run8("g128_64", 8'd128, 8'd64);

        // Backpressure: result held for 10 cycles
        out_ready8 = 1'b0;
        op8(8'd64, 8'd96, g8, lat);
        check("bp_gcd", g8, 32);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_gcd8 !== 8'd32 || out_valid8 !== 1'b1 || in_ready8 !== 1'b0)
                stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        check("bp_released", out_valid8, 0);
        check("bp_in_ready", in_ready8, 1);

        // Busy-ignore: second pair held on the input during RUN
        in_valid8 = 1'b1;
        in_a8 = 8'd255;
        in_b8 = 8'd1;
        @(posedge clk); #1;
        in_a8 = 8'd10;
        in_b8 = 8'd4;
        check("busy_ready", in_ready8, 0);
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("busy_first", out_gcd8, 1);
        check("busy_first_v", out_valid8, 1);
        @(posedge clk); #1;
        check("busy_idle", in_ready8, 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("busy_second", out_gcd8, 2);
        take8();

        // Async reset mid-RUN, between clock edges
        in_valid8 = 1'b1;
        in_a8 = 8'd200;
        in_b8 = 8'd150;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #2;
        nrst = 1'b0;
        #1;
        check("arst_valid", out_valid8, 0);
        check("arst_ready", in_ready8, 0);
        check("arst_gcd", out_gcd8, 0);
        #1;
        nrst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid8 !== 1'b0) seen = 1'b1;
        end
        check("arst_no_pulse", seen, 0);
        run8("g12_8", 8'd12, 8'd8);

        // WIDTH=16 random sweep against Euclid
        op16(16'hFFFF, 16'hFFFF, g16, lat);
        check("w16_max", g16, 65535);
        check("w16_max_lat", lat <= 34, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 4 == 1) begin
                ra = ra & 16'hFF00;
                rb = rb & 16'hFFF0;
            end
            if (i == 7) ra = 16'd0;
            op16(ra, rb, g16, lat);
            check($sformatf("w16_gcd_%0d_%0d", ra, rb), g16, ref_gcd(ra, rb));
            check($sformatf("w16_lat_%0d_%0d", ra, rb), lat <= 34 && lat >= 1, 1);
`ifdef GCD_COPRIME_EN
            check("w16_cop", out_coprime16, ref_gcd(ra, rb) == 1);
`endif
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
